// File: rtl/scl_share_arb_pkg.sv
// ============================================================================
// scl_share_arb_pkg : shared state encodings, data width and datapath function
// Revision: 1.0
// ============================================================================
`default_nettype none

package scl_share_arb_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] scl_dp(input logic [DATA_W-1:0] d);
    logic [1:0] sum;
    sum = d[1:0] + d[3:2];
    return {d[6] | d[7], d[6] & d[7], sum, d[1:0] ^ d[3:2], ~d[1], d[0]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/scl_rr_pick.sv
// ============================================================================
// scl_rr_pick : combinational round-robin picker (fixed priority when
//               SCL_ARB_FIXED_PRIO_EN is defined)
// Revision: 1.0
// ============================================================================
`default_nettype none

module scl_rr_pick
  import scl_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

`ifdef SCL_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) idx = ID_W'(k);
    end
  end
`else
  always_comb begin
    logic w_found;
    int   j;
    idx     = '0;
    w_found = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        idx     = ID_W'(j);
      end
    end
  end
`endif

  assign grant = (|req) ? (NUM_REQ'(1) << idx) : '0;

endmodule

`default_nettype wire

// File: rtl/scl_share_arb.sv
// ============================================================================
// scl_share_arb : shares one 8-bit datapath among NUM_REQ requesters with
//                 registered, backpressured results. Macro: SCL_ARB_FIXED_PRIO_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module scl_share_arb
  import scl_share_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     res_valid,
  output logic [DATA_W-1:0]        res_data,
  output logic [ID_W-1:0]          res_id,
  input  logic                     res_ready,
  output logic                     busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     w_ptr;
  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_idx;
  logic [DATA_W-1:0]   r_opnd;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   w_dp;
  logic                w_load;
  logic                w_calc;
  logic                w_done;

  scl_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (w_ptr),
    .grant (w_grant),
    .idx   (w_idx)
  );

  assign w_dp = scl_dp(r_opnd);
  assign busy = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_load      = 1'b0;
    w_calc      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          req_ready   = w_grant;
          w_load      = 1'b1;
          w_state_nxt = CALC;
        end
      end
      CALC: begin
        w_calc      = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (res_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_opnd    <= '0;
      r_id      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else begin
      if (w_load) begin
        r_opnd <= req_data[int'(w_idx)*DATA_W +: DATA_W];
        r_id   <= w_idx;
      end
      if (w_calc) begin
        res_data  <= w_dp;
        res_id    <= r_id;
        res_valid <= 1'b1;
      end
      if (w_done) res_valid <= 1'b0;
    end
  end

`ifdef SCL_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [ID_W-1:0] r_ptr;

  // Pointer advances only once the consumer has taken the result.
  always_ff @(posedge clk) begin
    if (!resetn)     r_ptr <= '0;
    else if (w_done) r_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
  end

  assign w_ptr = r_ptr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scl_share_arb.sv
// ============================================================================
// tb_scl_share_arb : directed self-checking bench for scl_share_arb
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_scl_share_arb;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 res_valid;
  logic [7:0]           res_data;
  logic [ID_W-1:0]      res_id;
  logic                 res_ready;
  logic                 busy;

  int n_chk  = 0;
  int n_fail = 0;

  scl_share_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dp_model(input logic [7:0] d);
    logic [7:0] o;
    o[0]   = d[0];
    o[1]   = ~d[1];
    o[3:2] = d[1:0] ^ d[3:2];
    o[5:4] = 2'((d[1:0] + d[3:2]) % 4);
    o[6]   = d[6] & d[7];
    o[7]   = d[6] | d[7];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  ops [NUM_REQ];
  logic [7:0]  hold_data;
  logic [1:0]  hold_id;
  int          exp_id;

  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;
    tick();
    tick();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'h00);
    check("rst_res_id",    32'(res_id),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Single request from requester 0, operand A5 -> A3
    resetn         = 1'b1;
    res_ready      = 1'b1;
    req_data[7:0]  = 8'hA5;
    req_valid      = 4'b0001;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    check("t1_ready_calc", 32'(req_ready), 32'h0);
    check("t1_busy_calc",  32'(busy),      32'd1);
    check("t1_nv_calc",    32'(res_valid), 32'd0);
    tick();
    check("t1_res_valid", 32'(res_valid), 32'd1);
    check("t1_res_data",  32'(res_data),  32'hA3);
    check("t1_res_id",    32'(res_id),    32'd0);
    tick();
    check("t1_res_clear", 32'(res_valid), 32'd0);
    check("t1_busy_idle", 32'(busy),      32'd0);

    // Datapath corners via requester 2 (pointer is 1, then 3)
    req_data[23:16] = 8'hFF;
    req_valid       = 4'b0100;
    #1;
    check("t2_req_ready_ff", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    check("t2_res_data_ff", 32'(res_data), 32'hE1);
    check("t2_res_id_ff",   32'(res_id),   32'd2);
    tick();
    req_data[23:16] = 8'h00;
    req_valid       = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    check("t2_res_data_00", 32'(res_data), 32'h02);
    check("t2_res_id_00",   32'(res_id),   32'd2);
    tick();

    // Pointer at 3, requests from 1 and 2 -> wraps past 3,0 to 1
    req_valid = 4'b0110;
    #1;
    check("wrap_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    check("wrap_res_id", 32'(res_id), 32'd1);
    tick();

    // Reset while in CALC discards the in-flight result
    req_valid = 4'b0001;
    #1;
    check("rstmid_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    resetn    = 1'b0;
    tick();
    check("rstmid_res_valid", 32'(res_valid), 32'd0);
    check("rstmid_busy",      32'(busy),      32'd0);
    resetn    = 1'b1;
    req_valid = 4'b1000;
    #1;
    check("rstmid_grant3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    tick();
    check("rstmid_res_id3", 32'(res_id), 32'd3);
    tick();
    check("rstmid_done", 32'(res_valid), 32'd0);

    // Fairness: all requesting, pointer back at 0
    ops[0] = 8'h11; ops[1] = 8'h3C; ops[2] = 8'hC3; ops[3] = 8'h5A;
    req_data  = {ops[3], ops[2], ops[1], ops[0]};
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
`ifdef SCL_ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = i % NUM_REQ;
`endif
      #1;
      check($sformatf("rr_grant_%0d", i), 32'(req_ready), 32'(1 << exp_id));
      tick();
      check($sformatf("rr_ready_calc_%0d", i), 32'(req_ready), 32'h0);
      tick();
      check($sformatf("rr_valid_%0d", i), 32'(res_valid), 32'd1);
      check($sformatf("rr_id_%0d", i),    32'(res_id),    32'(exp_id));
      check($sformatf("rr_data_%0d", i),  32'(res_data),  32'(dp_model(ops[exp_id])));
      tick();
    end
    req_valid = '0;
    tick();

    // Backpressure: requester 0 wins, then others wait while result is held
    res_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("bp_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b1110;
    tick();
    check("bp_valid", 32'(res_valid), 32'd1);
    hold_data = dp_model(ops[0]);
    hold_id   = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_valid_%0d", i), 32'(res_valid), 32'd1);
      check($sformatf("bp_hold_data_%0d", i),  32'(res_data),  32'(hold_data));
      check($sformatf("bp_hold_id_%0d", i),    32'(res_id),    32'(hold_id));
      check($sformatf("bp_no_ready_%0d", i),   32'(req_ready), 32'h0);
    end
    res_ready = 1'b1;
    tick();
    check("bp_released", 32'(res_valid), 32'd0);
    check("bp_next_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick();
    check("bp_next_id", 32'(res_id), 32'd1);
    tick();

    // Withdrawal: a pulse during CALC/RESP must not produce a grant or result
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0100;
    #1;
    check("wd_no_ready_calc", 32'(req_ready), 32'h0);
    tick();
    req_valid = '0;
    #1;
    check("wd_no_ready_resp", 32'(req_ready), 32'h0);
    tick();
    check("wd_idle_ready", 32'(req_ready), 32'h0);
    check("wd_idle_busy",  32'(busy),      32'd0);
    tick();
    check("wd_no_busy",   32'(busy),      32'd0);
    tick();
    check("wd_no_result", 32'(res_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
